// File: rtl/i2c_wb_ctrl.sv
// i2c_wb_ctrl: Wishbone B4 classic slave that fronts an I2C master core.
// Holds the transfer configuration and runs one core transaction per START.
// It also synchronises the core status flags, captures RX data and drives irq_o.
// Optional feature: define I2C_CTRL_TIMEOUT_EN to add a START-to-done watchdog
// and an ABORT state that holds the core disabled until it stops reporting busy.
module i2c_wb_ctrl #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [4:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        irq_o,
  output logic        core_en,
  output logic        core_mode,
  output logic        core_start,
  output logic        core_stop,
  output logic        core_rw,
  output logic [7:0]  core_tx,
  output logic [7:0]  core_slave_addr,
  output logic [7:0]  core_reg_addr,
  output logic [15:0] core_clk_div,
  input  logic [7:0]  core_rx,
  input  logic        core_busy,
  input  logic        core_done,
  input  logic        core_nack
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_CAPT  = 3'd3;
  localparam logic [2:0] S_ABORT = 3'd4;

  logic [2:0]  state_q, state_d;
  logic        en_q, en_d, rw_q, rw_d, irq_en_q, irq_en_d;
  logic [15:0] clkdiv_q, clkdiv_d;
  logic [7:0]  slave_q, slave_d, regad_q, regad_d, tx_q, tx_d, rx_q, rx_d;
  logic        done_st_q, done_st_d, nack_st_q, nack_st_d, ovr_q, ovr_d;
  logic        irq_q, irq_d, ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic        busy_m_q, busy_s_q, done_m_q, done_s_q, done_prev_q, nack_m_q, nack_s_q;
  logic        bus_req, wr, start_wr, done_rise, timeout_bit;
  logic [2:0]  reg_sel;
  logic [31:0] rdata;
  logic        unused_bits;

`ifdef I2C_CTRL_TIMEOUT_EN
  logic [23:0] cnt_q, cnt_d;
  logic        to_st_q, to_st_d;
  logic        to_hit;
  assign to_hit      = (cnt_q == TIMEOUT_CYCLES - 24'd1);
  assign timeout_bit = to_st_q;
  assign unused_bits = ^{wb_adr_i[1:0], wb_sel_i[3:2], wb_dat_i[31:16]};
`else
  assign timeout_bit = 1'b0;
  assign unused_bits = ^{wb_adr_i[1:0], wb_sel_i[3:2], wb_dat_i[31:16], TIMEOUT_CYCLES};
`endif

  assign reg_sel   = wb_adr_i[4:2];
  assign bus_req   = wb_cyc_i & wb_stb_i & ~ack_q;
  assign wr        = bus_req & wb_we_i;
  assign start_wr  = wr && (reg_sel == 3'd0) && wb_sel_i[1] && wb_dat_i[8];
  assign done_rise = done_s_q & ~done_prev_q;

  // Read mux: unused bits and the START pulse bit always read back as zero
  always_comb begin
    rdata = 32'h0;
    case (reg_sel)
      3'd0: rdata = {29'h0, irq_en_q, rw_q, en_q};
      3'd1: rdata = {27'h0, ovr_q, timeout_bit, nack_st_q, done_st_q, busy_s_q};
      3'd2: rdata = {16'h0, clkdiv_q};
      3'd3: rdata = {24'h0, slave_q};
      3'd4: rdata = {24'h0, regad_q};
      3'd5: rdata = {24'h0, tx_q};
      3'd6: rdata = {24'h0, rx_q};
      default: rdata = 32'h0;
    endcase
  end

  // Next-state logic: bus writes, W1C status, then FSM (status sets after clears so sets win)
  always_comb begin
    state_d   = state_q;
    en_d      = en_q;
    rw_d      = rw_q;
    irq_en_d  = irq_en_q;
    clkdiv_d  = clkdiv_q;
    slave_d   = slave_q;
    regad_d   = regad_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    done_st_d = done_st_q;
    nack_st_d = nack_st_q;
    ovr_d     = ovr_q;
`ifdef I2C_CTRL_TIMEOUT_EN
    to_st_d   = to_st_q;
    cnt_d     = cnt_q;
    if (state_q == S_REQ || state_q == S_RUN) cnt_d = cnt_q + 24'd1;
`endif
    ack_d = bus_req;
    dat_d = (bus_req && !wb_we_i) ? rdata : 32'h0;
    irq_d = irq_en_q & (done_st_q | nack_st_q | timeout_bit);

    if (wr) begin
      case (reg_sel)
        3'd0: if (wb_sel_i[0]) begin
          en_d     = wb_dat_i[0];
          rw_d     = wb_dat_i[1];
          irq_en_d = wb_dat_i[2];
        end
        3'd1: if (wb_sel_i[0]) begin
          if (wb_dat_i[1]) done_st_d = 1'b0;
          if (wb_dat_i[2]) nack_st_d = 1'b0;
`ifdef I2C_CTRL_TIMEOUT_EN
          if (wb_dat_i[3]) to_st_d = 1'b0;
`endif
          if (wb_dat_i[4]) ovr_d = 1'b0;
        end
        3'd2: begin
          if (wb_sel_i[0]) clkdiv_d[7:0]  = wb_dat_i[7:0];
          if (wb_sel_i[1]) clkdiv_d[15:8] = wb_dat_i[15:8];
        end
        3'd3: if (wb_sel_i[0]) slave_d = wb_dat_i[7:0];
        3'd4: if (wb_sel_i[0]) regad_d = wb_dat_i[7:0];
        3'd5: if (wb_sel_i[0]) tx_d = wb_dat_i[7:0];
        default: ;
      endcase
    end

    if (start_wr && state_q != S_IDLE) ovr_d = 1'b1;

    case (state_q)
      S_IDLE: if (start_wr) begin
        if (en_d) begin
          state_d = S_REQ;
`ifdef I2C_CTRL_TIMEOUT_EN
          cnt_d = 24'd0;
`endif
        end else begin
          ovr_d = 1'b1;
        end
      end
      S_REQ: begin
        if (!en_q) state_d = S_IDLE;
        else if (busy_s_q) state_d = S_RUN;
`ifdef I2C_CTRL_TIMEOUT_EN
        if (en_q && to_hit) begin
          to_st_d = 1'b1;
          state_d = S_ABORT;
        end
`endif
      end
      S_RUN: begin
        if (!en_q) state_d = S_IDLE;
        else if (done_rise) state_d = S_CAPT;
`ifdef I2C_CTRL_TIMEOUT_EN
        if (en_q && !done_rise && to_hit) begin
          to_st_d = 1'b1;
          state_d = S_ABORT;
        end
`endif
      end
      S_CAPT: begin
        if (rw_q) rx_d = core_rx;
        done_st_d = 1'b1;
        nack_st_d = nack_s_q;
        state_d   = S_IDLE;
      end
`ifdef I2C_CTRL_TIMEOUT_EN
      S_ABORT: if (!en_q || !busy_s_q) state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State registers and 2-FF synchronisers for the core flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      en_q <= 1'b0; rw_q <= 1'b0; irq_en_q <= 1'b0;
      clkdiv_q <= 16'h0; slave_q <= 8'h0; regad_q <= 8'h0; tx_q <= 8'h0; rx_q <= 8'h0;
      done_st_q <= 1'b0; nack_st_q <= 1'b0; ovr_q <= 1'b0;
      irq_q <= 1'b0; ack_q <= 1'b0; dat_q <= 32'h0;
      busy_m_q <= 1'b0; busy_s_q <= 1'b0; done_m_q <= 1'b0; done_s_q <= 1'b0;
      done_prev_q <= 1'b0; nack_m_q <= 1'b0; nack_s_q <= 1'b0;
`ifdef I2C_CTRL_TIMEOUT_EN
      cnt_q <= 24'h0; to_st_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      en_q <= en_d; rw_q <= rw_d; irq_en_q <= irq_en_d;
      clkdiv_q <= clkdiv_d; slave_q <= slave_d; regad_q <= regad_d; tx_q <= tx_d; rx_q <= rx_d;
      done_st_q <= done_st_d; nack_st_q <= nack_st_d; ovr_q <= ovr_d;
      irq_q <= irq_d; ack_q <= ack_d; dat_q <= dat_d;
      busy_m_q <= core_busy; busy_s_q <= busy_m_q;
      done_m_q <= core_done; done_s_q <= done_m_q; done_prev_q <= done_s_q;
      nack_m_q <= core_nack; nack_s_q <= nack_m_q;
`ifdef I2C_CTRL_TIMEOUT_EN
      cnt_q <= cnt_d; to_st_q <= to_st_d;
`endif
    end
  end

  // Core-facing outputs; EN is also masked at once so clearing it drops start/enable immediately
  assign core_en         = en_q & (state_q != S_ABORT);
  assign core_start      = en_q & (state_q == S_REQ);
  assign core_mode       = 1'b1;
  assign core_stop       = 1'b0;
  assign core_rw         = rw_q;
  assign core_tx         = tx_q;
  assign core_slave_addr = slave_q;
  assign core_reg_addr   = regad_q;
  assign core_clk_div    = clkdiv_q;
  assign wb_dat_o        = dat_q;
  assign wb_ack_o        = ack_q;
  assign irq_o           = irq_q;

endmodule

// File: tb/tb_i2c_wb_ctrl.sv
// Testbench for i2c_wb_ctrl: register table, core transactions, OVR, timeout, reset.
module tb_i2c_wb_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
  logic [4:0]  wb_adr_i = 5'h0;
  logic [31:0] wb_dat_i = 32'h0;
  logic [3:0]  wb_sel_i = 4'h0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o, irq_o, core_en, core_mode, core_start, core_stop, core_rw;
  logic [7:0]  core_tx, core_slave_addr, core_reg_addr;
  logic [15:0] core_clk_div;
  logic [7:0]  core_rx = 8'h0;
  logic        core_busy = 1'b0, core_done = 1'b0, core_nack = 1'b0;

  always #5 clk = ~clk;

  i2c_wb_ctrl #(.TIMEOUT_CYCLES(24'd100)) dut (
    .clk(clk), .rst(rst),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i), .wb_adr_i(wb_adr_i),
    .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .irq_o(irq_o), .core_en(core_en), .core_mode(core_mode), .core_start(core_start),
    .core_stop(core_stop), .core_rw(core_rw), .core_tx(core_tx),
    .core_slave_addr(core_slave_addr), .core_reg_addr(core_reg_addr),
    .core_clk_div(core_clk_div), .core_rx(core_rx), .core_busy(core_busy),
    .core_done(core_done), .core_nack(core_nack)
  );

  int errors = 0;
  int checks = 0;

  typedef struct { string name; logic [31:0] exp; } sb_t;
  sb_t sbq[$];
  sb_t sb_head;

  typedef struct { logic we; logic [2:0] r; logic [31:0] d; logic [31:0] exp; string name; } vec_t;
  vec_t vt[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  // Scoreboard: every ack pops the oldest expected read data (0 for writes)
  always @(negedge clk) begin
    if (wb_ack_o) begin
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_ack: got ack with empty scoreboard, expected none");
      end else begin
        sb_head = sbq.pop_front();
        chk(sb_head.name, wb_dat_o, sb_head.exp);
      end
    end
  end

  task automatic bus(input logic we, input logic [2:0] r, input logic [31:0] d,
                     input logic [31:0] exp, input string name);
    int n;
    sb_t rec;
    rec.name = name;
    rec.exp  = we ? 32'h0 : exp;
    sbq.push_back(rec);
    @(negedge clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = {r, 2'b00}; wb_dat_i = d; wb_sel_i = 4'hF;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!wb_ack_o && n < 10);
    if (!wb_ack_o) begin
      checks++; errors++;
      $display("FAIL ack_timeout_%s: got no ack in %0d cycles, expected ack", name, n);
      void'(sbq.pop_back());
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic wr(input logic [2:0] r, input logic [31:0] d, input string name);
    bus(1'b1, r, d, 32'h0, name);
  endtask

  task automatic rd(input logic [2:0] r, input logic [31:0] exp, input string name);
    bus(1'b0, r, 32'h0, exp, name);
  endtask

  function automatic logic sigval(input int w);
    case (w)
      0: return core_start;
      1: return irq_o;
      default: return core_en;
    endcase
  endfunction

  // Bounded wait for core_start(0)/irq_o(1)/core_en(2) to reach a level
  task automatic wait_for(input string name, input int w, input logic v, input int maxc, output int n);
    n = 0;
    while (sigval(w) !== v && n < maxc) begin
      @(posedge clk); #1; n++;
    end
    chk(name, {31'h0, sigval(w)}, {31'h0, v});
  endtask

  // Start a transfer and let the core model report busy until the FSM reaches RUN
  task automatic start_to_run(input logic [31:0] ctrl, input string name);
    int n;
    wr(3'd0, ctrl, name);
    chk({name, "_core_start"}, {31'h0, core_start}, 32'h1);
    @(negedge clk); core_busy = 1'b1;
    wait_for({name, "_in_run"}, 0, 1'b0, 10, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int starts;
    vt[0]  = '{1'b1, 3'd2, 32'hFFFF_1234, 32'h0,    "w_clkdiv_full"};
    vt[1]  = '{1'b0, 3'd2, 32'h0,         32'h1234, "r_clkdiv_mask"};
    vt[2]  = '{1'b1, 3'd2, 32'd124,       32'h0,    "w_clkdiv"};
    vt[3]  = '{1'b0, 3'd2, 32'h0,         32'd124,  "r_clkdiv"};
    vt[4]  = '{1'b1, 3'd3, 32'h0000_00A0, 32'h0,    "w_slave"};
    vt[5]  = '{1'b0, 3'd3, 32'h0,         32'hA0,   "r_slave"};
    vt[6]  = '{1'b1, 3'd4, 32'h0000_0010, 32'h0,    "w_reg"};
    vt[7]  = '{1'b0, 3'd4, 32'h0,         32'h10,   "r_reg"};
    vt[8]  = '{1'b1, 3'd5, 32'h0000_015A, 32'h0,    "w_tx"};
    vt[9]  = '{1'b0, 3'd5, 32'h0,         32'h5A,   "r_tx_mask"};
    vt[10] = '{1'b0, 3'd6, 32'h0,         32'h0,    "r_rx_reset"};
    vt[11] = '{1'b0, 3'd7, 32'h0,         32'h0,    "r_reg7"};
    vt[12] = '{1'b1, 3'd0, 32'h0000_0006, 32'h0,    "w_ctrl_noen"};
    vt[13] = '{1'b0, 3'd0, 32'h0,         32'h6,    "r_ctrl"};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_core_mode", {31'h0, core_mode}, 32'h1);
    chk("rst_irq", {31'h0, irq_o}, 32'h0);
    chk("rst_core_start", {31'h0, core_start}, 32'h0);
    chk("rst_core_en", {31'h0, core_en}, 32'h0);
    rst = 1'b0;
    rd(3'd0, 32'h0, "rst_ctrl");
    rd(3'd1, 32'h0, "rst_status");
    rd(3'd2, 32'h0, "rst_clkdiv");

    // Register table
    for (int i = 0; i < 14; i++) bus(vt[i].we, vt[i].r, vt[i].d, vt[i].exp, vt[i].name);
    chk("out_clkdiv", {16'h0, core_clk_div}, 32'd124);
    chk("out_slave", {24'h0, core_slave_addr}, 32'hA0);
    chk("out_reg", {24'h0, core_reg_addr}, 32'h10);
    chk("out_tx", {24'h0, core_tx}, 32'h5A);
    chk("out_rw", {31'h0, core_rw}, 32'h1);
    chk("out_en_off", {31'h0, core_en}, 32'h0);
    chk("out_stop", {31'h0, core_stop}, 32'h0);

    // Write transaction
    start_to_run(32'h105, "wr_txn");
    chk("wr_txn_rw", {31'h0, core_rw}, 32'h0);
    @(negedge clk); core_rx = 8'h77; core_done = 1'b1; core_busy = 1'b0;
    wait_for("wr_txn_irq", 1, 1'b1, 10, n);
    chk("wr_txn_irq_latency", {31'h0, (n <= 6)}, 32'h1);
    @(negedge clk); core_done = 1'b0;
    rd(3'd1, 32'h02, "wr_txn_status");
    rd(3'd6, 32'h0, "wr_txn_rx_unchanged");
    wr(3'd1, 32'h02, "w1c_done");
    rd(3'd1, 32'h0, "status_cleared");
    wait_for("irq_cleared", 1, 1'b0, 4, n);

    // Read transaction with NACK
    start_to_run(32'h107, "rd_txn");
    chk("rd_txn_rw", {31'h0, core_rw}, 32'h1);
    @(negedge clk); core_rx = 8'hC3; core_nack = 1'b1; core_done = 1'b1; core_busy = 1'b0;
    wait_for("rd_txn_irq", 1, 1'b1, 10, n);
    @(negedge clk); core_done = 1'b0; core_nack = 1'b0;
    rd(3'd6, 32'hC3, "rd_txn_rxdata");
    rd(3'd1, 32'h06, "rd_txn_status");
    wr(3'd1, 32'h06, "w1c_done_nack");
    rd(3'd1, 32'h0, "status_cleared2");
    wait_for("irq_cleared2", 1, 1'b0, 4, n);

    // START during RUN: OVR and no second start request
    start_to_run(32'h105, "ovr_txn");
    wr(3'd0, 32'h105, "start_in_run");
    starts = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (core_start) starts++;
    end
    chk("no_second_start", starts, 0);
    rd(3'd1, 32'h11, "ovr_status_busy");
    @(negedge clk); core_done = 1'b1; core_busy = 1'b0;
    wait_for("ovr_txn_irq", 1, 1'b1, 10, n);
    @(negedge clk); core_done = 1'b0;
    rd(3'd1, 32'h12, "ovr_done_status");
    wr(3'd1, 32'h1E, "w1c_all");
    rd(3'd1, 32'h0, "status_cleared3");

    // START with EN=0
    wr(3'd0, 32'h100, "start_en0");
    chk("start_en0_no_start", {31'h0, core_start}, 32'h0);
    rd(3'd1, 32'h10, "start_en0_ovr");
    wr(3'd1, 32'h10, "w1c_ovr");

    // EN cleared during RUN
    start_to_run(32'h105, "enclr_txn");
    wr(3'd0, 32'h004, "en_clear");
    chk("enclr_core_en", {31'h0, core_en}, 32'h0);
    chk("enclr_core_start", {31'h0, core_start}, 32'h0);
    rd(3'd1, 32'h01, "enclr_status");
    @(negedge clk); core_busy = 1'b0;
    repeat (3) @(negedge clk);
    rd(3'd1, 32'h0, "enclr_status_idle");

    // Core never reports done
    start_to_run(32'h105, "to_txn");
`ifdef I2C_CTRL_TIMEOUT_EN
    wait_for("to_core_en_low", 2, 1'b0, 120, n);
    rd(3'd1, 32'h09, "to_status");
    chk("to_irq", {31'h0, irq_o}, 32'h1);
    @(negedge clk); core_busy = 1'b0;
    wait_for("to_back_idle", 2, 1'b1, 10, n);
    rd(3'd1, 32'h08, "to_status_idle");
    wr(3'd1, 32'h08, "w1c_to");
    start_to_run(32'h105, "rst_txn");
`else
    repeat (120) @(posedge clk);
    #1;
    chk("noto_core_en", {31'h0, core_en}, 32'h1);
    chk("noto_core_start", {31'h0, core_start}, 32'h0);
    rd(3'd1, 32'h01, "noto_status");
`endif

    // Reset mid-RUN
    @(negedge clk); rst = 1'b1; core_busy = 1'b0;
    #1;
    chk("midrst_core_start", {31'h0, core_start}, 32'h0);
    chk("midrst_core_en", {31'h0, core_en}, 32'h0);
    chk("midrst_core_mode", {31'h0, core_mode}, 32'h1);
    @(negedge clk); rst = 1'b0;
    rd(3'd1, 32'h0, "midrst_status");
    rd(3'd0, 32'h0, "midrst_ctrl");

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
